i2c_line_conditioner: RTL and testbench
=======================================

// Module: i2c_line_conditioner
// PURPOSE
//   Front end between the raw I2C pads and the I2C bit-level FSM. Synchronises SCL/SDA,
//   rejects short glitches, and produces the single-cycle strobes the FSM consumes:
//   rx_edge (SCL rise, sample SDA), tx_edge (SCL fall, shift), plus START/STOP detect
//   and a bus-busy flag. Clocked entirely in the pclk domain.
// PARAMETERS
//   SYNC_STAGES  2  synchroniser flops per line (>=2)
//   FILT_CNT     3  consecutive pclk cycles a new level must persist before it is accepted (>=1)
// PORTS
//   pclk        in   1  system clock
//   preset_n    in   1  asynchronous active-low reset
//   scl_i       in   1  raw SCL pad input (asynchronous)
//   sda_i       in   1  raw SDA pad input (asynchronous)
//   filt_en     in   1  1: glitch filter active; 0: filter bypassed
//   scl_in      out  1  conditioned SCL level
//   sda_in      out  1  conditioned SDA level
//   rx_edge     out  1  1-cycle pulse: conditioned SCL 0->1
//   tx_edge     out  1  1-cycle pulse: conditioned SCL 1->0
//   start_det   out  1  1-cycle pulse: START (or repeated START)
//   stop_det    out  1  1-cycle pulse: STOP
//   bus_busy    out  1  high between START and STOP
// BEHAVIOUR
//   Reset (async, preset_n=0): all synchroniser flops, scl_in, sda_in, scl_d, sda_d = 1
//     (idle bus); filter counters = 0; bus_busy = 0; all pulses = 0.
//   Synchroniser: per line, SYNC_STAGES-deep shift chain; last stage = sync value.
//   Filter (per line, filt_en=1): counter of width $clog2(FILT_CNT+1).
//     - sync == filtered: counter cleared.
//     - sync != filtered, counter < FILT_CNT-1: counter++.
//     - sync != filtered, counter == FILT_CNT-1: filtered <= sync, counter <= 0.
//     - Pulse lasting < FILT_CNT cycles at sync output never reaches filtered.
//   Bypass (filt_en=0): filtered <= sync every cycle, counters held at 0. filt_en may
//     change any time; on 1->0 counters clear that cycle; no spurious output toggle.
//   Latency pin->scl_in/sda_in: SYNC_STAGES+FILT_CNT pclk edges (filter on),
//     SYNC_STAGES+1 (bypass). SCL and SDA paths have identical latency.
//   Event logic: scl_d/sda_d = filtered values delayed one pclk.
//     rx_edge   = scl_in & ~scl_d
//     tx_edge   = ~scl_in & scl_d
//     start_det = scl_in & scl_d & sda_d & ~sda_in
//     stop_det  = scl_in & scl_d & ~sda_d & sda_in
//     All decoded from flops only; no combinational path from scl_i/sda_i to outputs.
//   Simultaneous SCL and SDA change in the same cycle: edge pulse fires, start/stop
//     do NOT (SCL must be high in both cycles).
//   bus_busy: set the cycle after start_det; cleared the cycle after stop_det; repeated
//     START keeps it 1. start_det and stop_det are mutually exclusive by construction.
//   Reset mid-transfer: all state returns to reset values immediately; first cycles after
//     release see idle-high, so a low line yields a tx_edge/level change only after
//     full latency, never a start_det unless SDA falls while SCL stays high.
// TESTING
//   T1 reset: scl_i=sda_i=1, preset_n pulsed -> scl_in=sda_in=1, bus_busy=0, no pulses.
//   T2 START: SCL=1, SDA 1->0 (filter on, defaults) -> start_det single pulse 5 edges
//      after SDA fall; bus_busy=1 next cycle; rx_edge/tx_edge stay 0.
//   T3 byte clocking: 9 SCL periods of 40 pclk -> exactly 9 rx_edge and 9 tx_edge pulses,
//      each 1 cycle wide, rx_edge 5 cycles after each scl_i rise.
//   T4 glitch: FILT_CNT=3, SCL low pulse of 2 pclk -> no tx_edge, scl_in stays 1;
//      pulse of 3 pclk -> tx_edge then rx_edge.
//   T5 STOP + bypass: filt_en=0, SCL=1, SDA 0->1 -> stop_det 3 edges later, bus_busy 0 next cycle.
//   T6 async reset during bus_busy=1 with SCL low -> outputs to reset values same cycle,
//      no start_det after release.

Source files
------------

// File: rtl/i2c_line_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_line_conditioner
//
// Front end between the raw I2C pads and the bit-level I2C FSM. Each line
// (SCL, SDA) is brought into the pclk domain by a synchroniser chain. It then
// passes through a persistence filter that only accepts a new level once the
// level has held for FILT_CNT consecutive cycles. The filtered levels are
// delayed by one more cycle so that bus events can be decoded purely from
// flops.
//
// Ports
//   pclk       in   system clock (everything runs in this domain)
//   preset_n   in   asynchronous active-low reset
//   scl_i      in   raw SCL pad input (asynchronous)
//   sda_i      in   raw SDA pad input (asynchronous)
//   filt_en    in   1: glitch filter active, 0: filter bypassed
//   scl_in     out  conditioned SCL level
//   sda_in     out  conditioned SDA level
//   rx_edge    out  1-cycle pulse on conditioned SCL rise (sample SDA)
//   tx_edge    out  1-cycle pulse on conditioned SCL fall (shift)
//   start_det  out  1-cycle pulse on START / repeated START
//   stop_det   out  1-cycle pulse on STOP
//   bus_busy   out  high from the cycle after START until the cycle after STOP
// ---------------------------------------------------------------------------
module i2c_line_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 3
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic scl_i,
    input  logic sda_i,
    input  logic filt_en,
    output logic scl_in,
    output logic sda_in,
    output logic rx_edge,
    output logic tx_edge,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    localparam int CW = $clog2(FILT_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    // Index 0 carries SCL, index 1 carries SDA, so both lines share one
    // implementation and therefore have identical latency.
    logic [1:0]                  raw;
    logic [1:0][SYNC_STAGES-1:0] chain;
    logic [1:0]                  sync;
    logic [1:0][CW-1:0]          cnt;
    logic [1:0]                  filt;
    logic [1:0]                  filt_d;
    logic                        busy;

    assign raw  = {sda_i, scl_i};
    assign sync = {chain[1][SYNC_STAGES-1], chain[0][SYNC_STAGES-1]};

    // Synchroniser chains and persistence filters. Reset loads the idle-high
    // bus level everywhere, so a line that is low at release is treated as
    // a fresh change and goes through the full latency.
    // Any cycle in which the synchronised value equals the accepted level
    // restarts the count. A pulse shorter than FILT_CNT cycles is therefore
    // never accepted. In bypass the accepted level follows the synchroniser
    // directly, and the counters are held at zero. Re-enabling the filter
    // thus starts from a clean count.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            chain <= '1;
            cnt   <= '0;
            filt  <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                chain[i] <= {chain[i][SYNC_STAGES-2:0], raw[i]};
                if (!filt_en) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // One-cycle history of the accepted levels, plus the busy flag. A START
    // arms busy and a STOP clears it. A repeated START simply re-arms it.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            filt_d <= 2'b11;
            busy   <= 1'b0;
        end else begin
            filt_d <= filt;
            if (start_det) begin
                busy <= 1'b1;
            end else if (stop_det) begin
                busy <= 1'b0;
            end
        end
    end

    // START and STOP require SCL high in both the current and the previous
    // cycle. If SCL and SDA move together, only the SCL edge pulse fires.
    assign scl_in    = filt[0];
    assign sda_in    = filt[1];
    assign rx_edge   = filt[0] & ~filt_d[0];
    assign tx_edge   = ~filt[0] & filt_d[0];
    assign start_det = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
    assign stop_det  = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];
    assign bus_busy  = busy;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// ---------------------------------------------------------------------------
// tb_i2c_line_conditioner
//
// Bench for i2c_line_conditioner with the default parameters.
//
// Stimulus is driven on the falling clock edge. A reference model predicts
// the output vector after each rising edge and queues every predicted change.
// A monitor samples the DUT shortly after each rising edge. Whenever the DUT
// presents a change, or a change is due, the monitor pops the queue and
// compares.
//
// Reference model. The pin seen by the filter is the pad value from
// SYNC_STAGES edges earlier. With the filter on, the conditioned level moves
// to a new value only if that delayed pin has shown the new value, with the
// filter enabled, for each of the last FILT_CNT edges. With the filter off,
// the conditioned level simply follows the delayed pin.
// ---------------------------------------------------------------------------
module tb_i2c_line_conditioner;

    localparam int S = 2;
    localparam int F = 3;
    localparam logic [6:0] IDLE_OUTS = 7'b1100000;

    logic pclk = 1'b0;
    logic preset_n, scl_i, sda_i, filt_en;
    logic scl_in, sda_in, rx_edge, tx_edge, start_det, stop_det, bus_busy;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int start_cnt = 0;

    typedef struct packed {
        int         cyc;
        logic [6:0] outs;
    } exp_t;
    exp_t sb[$];

    // reference model state
    logic scl_hist[$];
    logic sda_hist[$];
    bit   en_hist[$];
    logic [1:0] m_lvl;
    logic [1:0] m_d;
    logic       m_busy;
    logic [6:0] m_prev;

    i2c_line_conditioner #(.SYNC_STAGES(S), .FILT_CNT(F)) dut (
        .pclk(pclk), .preset_n(preset_n), .scl_i(scl_i), .sda_i(sda_i),
        .filt_en(filt_en), .scl_in(scl_in), .sda_in(sda_in),
        .rx_edge(rx_edge), .tx_edge(tx_edge), .start_det(start_det),
        .stop_det(stop_det), .bus_busy(bus_busy)
    );

    always #5 pclk = ~pclk;

    // rising-edge counter used to time-stamp predictions
    always @(posedge pclk) edge_no <= edge_no + 1;

    // The output vector follows directly from the two levels and their
    // one-cycle history.
    function automatic logic [6:0] outsOf(input logic [1:0] lvl, input logic [1:0] d, input logic busy);
        return {lvl[0], lvl[1], lvl[0] & ~d[0], ~lvl[0] & d[0],
                lvl[0] & d[0] & d[1] & ~lvl[1], lvl[0] & d[0] & ~d[1] & lvl[1], busy};
    endfunction

    function automatic logic pinAt(input int line, input int back);
        if (line == 0) return scl_hist[scl_hist.size() - 1 - back];
        return sda_hist[sda_hist.size() - 1 - back];
    endfunction

    // The new level is accepted only after it has persisted for FILT_CNT
    // consecutive enabled edges.
    function automatic logic modelLevel(input int line, input logic cur);
        int   n;
        logic s;
        n = en_hist.size();
        s = pinAt(line, S);
        if (!en_hist[n-1]) return s;
        if (s == cur) return cur;
        for (int k = 0; k < F; k++) begin
            if (pinAt(line, S + k) != s || !en_hist[n-1-k]) return cur;
        end
        return s;
    endfunction

    // Return the model to an idle bus. The history is pre-filled with idle
    // pins and disabled-filter entries, so no change can be credited to
    // edges that occurred before the reset.
    task automatic modelReset();
        scl_hist.delete();
        sda_hist.delete();
        en_hist.delete();
        for (int k = 0; k < S + F; k++) begin
            scl_hist.push_back(1'b1);
            sda_hist.push_back(1'b1);
            en_hist.push_back(1'b0);
        end
        m_lvl  = 2'b11;
        m_d    = 2'b11;
        m_busy = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by one edge, and queue
    // any predicted output change.
    task automatic applyStimulus(input logic scl, input logic sda, input logic en, input logic rst_n);
        logic [6:0] cur;
        logic [6:0] nxt;
        logic [1:0] lvl_new;
        @(negedge pclk);
        scl_i    = scl;
        sda_i    = sda;
        filt_en  = en;
        preset_n = rst_n;
        if (!rst_n) begin
            modelReset();
        end else begin
            cur = outsOf(m_lvl, m_d, m_busy);
            scl_hist.push_back(scl);
            sda_hist.push_back(sda);
            en_hist.push_back(en);
            lvl_new[0] = modelLevel(0, m_lvl[0]);
            lvl_new[1] = modelLevel(1, m_lvl[1]);
            if (cur[2]) m_busy = 1'b1;
            else if (cur[1]) m_busy = 1'b0;
            m_d   = m_lvl;
            m_lvl = lvl_new;
        end
        nxt = outsOf(m_lvl, m_d, m_busy);
        if (nxt != m_prev) sb.push_back('{cyc: edge_no + 1, outs: nxt});
        m_prev = nxt;
    endtask

    task automatic hold(input int n, input logic scl, input logic sda, input logic en);
        for (int k = 0; k < n; k++) applyStimulus(scl, sda, en, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: compares each DUT output change against the queued prediction
    // for that edge, and flags any prediction whose edge has passed unseen.
    initial begin : monitor
        logic [6:0] dut_outs;
        logic [6:0] dut_prev;
        exp_t e;
        dut_prev = IDLE_OUTS;
        forever begin
            @(posedge pclk);
            #2;
            dut_outs = {scl_in, sda_in, rx_edge, tx_edge, start_det, stop_det, bus_busy};
            if (rx_edge === 1'b1) rx_cnt++;
            if (tx_edge === 1'b1) tx_cnt++;
            if (start_det === 1'b1) start_cnt++;
            while (sb.size() > 0 && sb[0].cyc < edge_no) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed_change cycle=%0d actual=none required=%b", e.cyc, e.outs);
            end
            if (sb.size() > 0 && sb[0].cyc == edge_no) begin
                e = sb.pop_front();
                checks++;
                if (dut_outs !== e.outs) begin
                    errors++;
                    $display("[TB] FAIL outputs cycle=%0d actual=%b required=%b", edge_no, dut_outs, e.outs);
                end
            end else if (dut_outs !== dut_prev) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_change cycle=%0d actual=%b required=%b", edge_no, dut_outs, dut_prev);
            end
            dut_prev = dut_outs;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int rx0, tx0, st0;
        logic r_scl, r_sda, r_en;
        scl_i    = 1'b1;
        sda_i    = 1'b1;
        filt_en  = 1'b1;
        preset_n = 1'b1;
        m_prev   = IDLE_OUTS;
        modelReset();
        #2;

        // T1: reset pulse with an idle bus
        preset_n = 1'b0;
        #1;
        checkOutput("t1_idle_outs", {25'd0, scl_in, sda_in, rx_edge, tx_edge, start_det, stop_det, bus_busy}, {25'd0, IDLE_OUTS});
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        hold(6, 1'b1, 1'b1, 1'b1);

        // T2: START with the filter on
        hold(4, 1'b1, 1'b0, 1'b1);
        @(posedge pclk); #1;
        checkOutput("t2_no_start_early", start_det, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge pclk); #1;
        checkOutput("t2_start_at_5", start_det, 1'b1);
        checkOutput("t2_no_rx", rx_edge, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge pclk); #1;
        checkOutput("t2_busy_next", bus_busy, 1'b1);
        checkOutput("t2_start_single", start_det, 1'b0);

        // T3: nine SCL periods of 40 pclk each
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        for (int b = 0; b < 9; b++) begin
            r_sda = (b == 8) ? 1'b0 : 1'($urandom_range(0, 1));
            hold(10, 1'b0, sda_i, 1'b1);
            hold(10, 1'b0, r_sda, 1'b1);
            hold(20, 1'b1, r_sda, 1'b1);
        end
        hold(8, 1'b1, 1'b0, 1'b1);
        checkOutput("t3_rx_count", rx_cnt - rx0, 9);
        checkOutput("t3_tx_count", tx_cnt - tx0, 9);

        // STOP with the filter on, then a quiet bus
        hold(10, 1'b1, 1'b1, 1'b1);
        checkOutput("t3_busy_cleared", bus_busy, 1'b0);

        // T4: SCL glitches of 2 and 3 cycles
        tx0 = tx_cnt;
        rx0 = rx_cnt;
        hold(2, 1'b0, 1'b1, 1'b1);
        hold(10, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_glitch2_tx", tx_cnt - tx0, 0);
        checkOutput("t4_glitch2_level", scl_in, 1'b1);
        hold(3, 1'b0, 1'b1, 1'b1);
        hold(12, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_glitch3_tx", tx_cnt - tx0, 1);
        checkOutput("t4_glitch3_rx", rx_cnt - rx0, 1);

        // T5: START then STOP with the filter bypassed
        hold(4, 1'b1, 1'b1, 1'b0);
        hold(6, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_busy_set", bus_busy, 1'b1);
        hold(2, 1'b1, 1'b1, 1'b0);
        @(posedge pclk); #1;
        checkOutput("t5_no_stop_early", stop_det, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge pclk); #1;
        checkOutput("t5_stop_at_3", stop_det, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge pclk); #1;
        checkOutput("t5_busy_cleared", bus_busy, 1'b0);

        // T6: async reset while busy with SCL low
        hold(8, 1'b1, 1'b0, 1'b1);
        hold(10, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_busy_before", bus_busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("t6_reset_busy", bus_busy, 1'b0);
        checkOutput("t6_reset_scl", scl_in, 1'b1);
        checkOutput("t6_reset_sda", sda_in, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        st0 = start_cnt;
        tx0 = tx_cnt;
        hold(12, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_no_start", start_cnt - st0, 0);
        checkOutput("t6_tx_after_release", tx_cnt - tx0, 1);
        hold(10, 1'b1, 1'b0, 1'b1);
        hold(10, 1'b1, 1'b1, 1'b1);

        // Random segments: arbitrary hold lengths, including glitches,
        // filter toggling and occasional resets
        r_en = 1'b1;
        for (int seg = 0; seg < 400; seg++) begin
            r_scl = 1'($urandom_range(0, 1));
            r_sda = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) r_en = ~r_en;
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) applyStimulus(r_scl, r_sda, r_en, 1'b0);
            end else begin
                hold(int'($urandom_range(1, 8)), r_scl, r_sda, r_en);
            end
        end

        hold(12, 1'b1, 1'b1, 1'b1);
        @(posedge pclk); #4;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
